// File: rtl/noc_pkg.sv
// Shared router constants: packet width, requester slots, arbiter state encoding and
// header field positions used by the routing units.
package noc_pkg;

   localparam int unsigned PKT_W   = 64;
   localparam int unsigned NUM_REQ = 4;

   // Requester slots at an output arbiter; the PE input takes slot 0 on direction outputs.
   localparam int unsigned REQ_PE = 0;
   localparam int unsigned REQ_0  = 0;
   localparam int unsigned REQ_1  = 1;
   localparam int unsigned REQ_2  = 2;
   localparam int unsigned REQ_3  = 3;

   // Header fields edited by the routing units; the arbiter passes them through untouched.
   localparam int unsigned DIR_X_BIT = 58;
   localparam int unsigned DIR_Y_BIT = 57;
   localparam int unsigned HOP_X_MSB = 56;
   localparam int unsigned HOP_X_LSB = 55;
   localparam int unsigned HOP_Y_MSB = 54;
   localparam int unsigned HOP_Y_LSB = 53;

   typedef enum logic {
      StIdle  = 1'b0,
      StGrant = 1'b1
   } arb_state_e;

endpackage

// File: rtl/noc_out_arbiter_if.sv
// Requester/FIFO side bundle of one router output arbiter.
interface noc_out_arbiter_if
   import noc_pkg::*;
#(
   parameter int unsigned W = PKT_W,
   parameter int unsigned N = NUM_REQ
);
   logic [N-1:0]   pend;
   logic [N-1:0]   req;
   logic [N*W-1:0] in_packet;
   logic [N-1:0]   full;
   logic           out_full;
   logic [W-1:0]   out_packet;
   logic           out_wr;
   logic [1:0]     gnt_id;
   logic           err;

   modport slave (
      input  pend, req, in_packet, out_full,
      output full, out_packet, out_wr, gnt_id, err
   );

   modport master (
      output pend, req, in_packet, out_full,
      input  full, out_packet, out_wr, gnt_id, err
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pend_i scanning upward from ptr_i,
// wrapping 3 -> 0.
module rr_pick (
   input  logic [3:0] pend_i,
   input  logic [1:0] ptr_i,
   output logic [3:0] sel_o,
   output logic [1:0] idx_o,
   output logic       any_o
);

   always_comb begin
      idx_o = ptr_i;
      any_o = |pend_i;
      // Scan from the far end so the candidate nearest ptr_i is written last and wins.
      for (int k = 3; k >= 0; k--) begin
         if (pend_i[ptr_i + 2'(k)]) begin
            idx_o = ptr_i + 2'(k);
         end
      end
      sel_o = any_o ? (4'b0001 << idx_o) : 4'b0000;
   end

endmodule

// File: rtl/noc_out_arbiter.sv
// Round-robin arbiter for one router output link. The grant is registered so that
// full never depends on req, breaking the loop through the routing units.
module noc_out_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned W = PKT_W,
   parameter int unsigned N = NUM_REQ
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   noc_out_arbiter_if.slave  bus
);

   arb_state_e     state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [1:0]     ptr_q, ptr_d;
   logic [W-1:0]   out_packet_q, out_packet_d;
   logic           out_wr_q, out_wr_d;
   logic [1:0]     gnt_id_q, gnt_id_d;
   logic           err_q, err_d;

   logic [N-1:0]   full;
   logic [N-1:0]   xfer_vec;
   logic           illegal;
   logic [3:0]     pick_sel;
   logic [1:0]     pick_idx;
   logic           pick_any;

   rr_pick u_rr_pick (
      .pend_i (bus.pend),
      .ptr_i  (ptr_q),
      .sel_o  (pick_sel),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   always_comb begin
      full     = ~(gnt_q & {N{~bus.out_full}});
      xfer_vec = gnt_q & bus.req & ~full;
      illegal  = |(bus.req & full);
   end

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      ptr_d        = ptr_q;
      out_packet_d = out_packet_q;
      out_wr_d     = 1'b0;
      gnt_id_d     = gnt_id_q;
      // Strobes against a full requester are dropped but remembered until reset.
      err_d        = err_q | illegal;

      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               gnt_d    = pick_sel;
               gnt_id_d = pick_idx;
               state_d  = StGrant;
            end
         end
         StGrant: begin
            if (|xfer_vec) begin
               for (int i = 0; i < int'(N); i++) begin
                  if (gnt_q[i]) begin
                     out_packet_d = bus.in_packet[i*W +: W];
                  end
               end
               out_wr_d = 1'b1;
               ptr_d    = gnt_id_q + 2'd1;
               gnt_d    = '0;
               state_d  = StIdle;
            end else if (!(|(gnt_q & bus.pend))) begin
               gnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         gnt_q        <= '0;
         ptr_q        <= '0;
         out_packet_q <= '0;
         out_wr_q     <= 1'b0;
         gnt_id_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         ptr_q        <= ptr_d;
         out_packet_q <= out_packet_d;
         out_wr_q     <= out_wr_d;
         gnt_id_q     <= gnt_id_d;
         err_q        <= err_d;
      end
   end

   assign bus.full       = full;
   assign bus.out_packet = out_packet_q;
   assign bus.out_wr     = out_wr_q;
   assign bus.gnt_id     = gnt_id_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Randomised bench for noc_out_arbiter: requester models drive the bus, an abstract
// arbitration model predicts writes into a scoreboard checked by a separate monitor.
module tb_noc_out_arbiter;
   import noc_pkg::*;

   localparam int unsigned W = PKT_W;
   localparam int unsigned N = NUM_REQ;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b1;

   noc_out_arbiter_if #(.W(W), .N(N)) bus ();

   noc_out_arbiter #(.W(W), .N(N)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int passed = 0;

   logic [W-1:0] exp_q[$];
   bit           has [N];
   logic [W-1:0] pkt [N];

   // Reference model: granted requester (-1 = none), rotating priority start, flags.
   int m_gnt    = -1;
   int m_ptr    = 0;
   int m_id     = 0;
   bit m_err    = 1'b0;
   bit rst_done = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_gnt = -1;
      m_ptr = 0;
      m_id  = 0;
      m_err = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] pend_v, input logic [N-1:0] req_v,
                             input logic of, input logic [N-1:0] efull);
      for (int j = 0; j < int'(N); j++) begin
         if (req_v[j] && efull[j]) m_err = 1'b1;
      end
      if (m_gnt < 0) begin
         for (int k = 0; k < int'(N); k++) begin
            int c;
            c = (m_ptr + k) % int'(N);
            if (pend_v[c]) begin
               m_gnt = c;
               m_id  = c;
               break;
            end
         end
      end else if (req_v[m_gnt] && !of) begin
         exp_q.push_back(pkt[m_gnt]);
         has[m_gnt] = 1'b0;
         m_ptr      = (m_gnt + 1) % int'(N);
         m_gnt      = -1;
      end else if (!pend_v[m_gnt]) begin
         m_gnt = -1;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk_i);
      rst_ni  = 1'b0;
      bus.req = '0;
      model_reset();
   endtask

   task automatic do_cycle(input int arrive_pct, input int drop_pct, input int of_pct,
                           input int bad_pct, input bit rst_xfer);
      logic [N-1:0] efull;
      logic [N-1:0] pend_v;
      logic [N-1:0] req_v;
      @(negedge clk_i);
      if (!rst_ni) rst_ni = 1'b1;
      check("err", W'(bus.err), W'(m_err));
      check("gnt_id", W'(bus.gnt_id), W'(m_id));
      for (int i = 0; i < int'(N); i++) begin
         if (!has[i] && int'($urandom_range(0, 99)) < arrive_pct) begin
            has[i] = 1'b1;
            pkt[i] = {$urandom(), $urandom()};
         end else if (has[i] && int'($urandom_range(0, 99)) < drop_pct) begin
            has[i] = 1'b0;
         end
         pend_v[i] = has[i];
         bus.in_packet[i*W +: W] = pkt[i];
      end
      bus.pend     = pend_v;
      bus.out_full = int'($urandom_range(0, 99)) < of_pct;
      #1;
      for (int j = 0; j < int'(N); j++) efull[j] = !(m_gnt == j && !bus.out_full);
      check("full", W'(bus.full), W'(efull));
      req_v = pend_v & ~bus.full;
      if (int'($urandom_range(0, 99)) < bad_pct) begin
         int j;
         j = int'($urandom_range(0, N - 1));
         if (bus.full[j]) req_v[j] = 1'b1;
      end
      bus.req = req_v;
      if (rst_xfer && m_gnt >= 0 && req_v[m_gnt] && !bus.out_full) begin
         rst_ni = 1'b0;
         #1;
         check("rst_full", W'(bus.full), W'({N{1'b1}}));
         check("rst_wr", W'(bus.out_wr), '0);
         bus.req = '0;
         model_reset();
         rst_done = 1'b1;
         return;
      end
      model_step(pend_v, req_v, bus.out_full, efull);
   endtask

   // Scoreboard monitor: every write must match the oldest predicted packet.
   always @(negedge clk_i) begin
      if (bus.out_wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_wr", W'(1), W'(0));
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("out_packet", bus.out_packet, e);
         end
      end
   end

   initial begin
      bus.pend      = '0;
      bus.req       = '0;
      bus.in_packet = '0;
      bus.out_full  = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         has[i] = 1'b0;
         pkt[i] = '0;
      end
      #1 rst_ni = 1'b0;
      #1;
      check("reset_full", W'(bus.full), W'({N{1'b1}}));
      check("reset_wr", W'(bus.out_wr), '0);
      check("reset_pkt", bus.out_packet, '0);
      check("reset_gnt_id", W'(bus.gnt_id), '0);
      check("reset_err", W'(bus.err), '0);

      // Lone requester 2, then all four from a fresh pointer with 0 re-pending.
      has[2] = 1'b1;
      pkt[2] = 64'hA5A5_0002_DEAD_BEEF;
      repeat (4) do_cycle(0, 0, 0, 0, 1'b0);
      apply_reset();
      for (int i = 0; i < int'(N); i++) begin
         has[i] = 1'b1;
         pkt[i] = {32'hC0DE_0000 + i, $urandom()};
      end
      repeat (2) do_cycle(0, 0, 0, 0, 1'b0);
      has[0] = 1'b1;
      pkt[0] = 64'h0000_0000_0BAD_CAFE;
      repeat (10) do_cycle(0, 0, 0, 0, 1'b0);

      // Requester 1 held off by a full FIFO for five cycles.
      apply_reset();
      has[1] = 1'b1;
      pkt[1] = 64'h1111_2222_3333_4444;
      do_cycle(0, 0, 0, 0, 1'b0);
      repeat (5) do_cycle(0, 0, 100, 0, 1'b0);
      repeat (3) do_cycle(0, 0, 0, 0, 1'b0);

      repeat (80) do_cycle(30, 15, 20, 0, 1'b0);
      repeat (300) do_cycle(40, 3, 25, 0, 1'b0);
      repeat (40) do_cycle(40, 0, 10, 25, 1'b0);

      for (int n = 0; n < 100 && !rst_done; n++) do_cycle(60, 0, 0, 0, 1'b1);
      if (!rst_done) check("rst_xfer_seen", W'(0), W'(1));
      repeat (40) do_cycle(0, 0, 0, 0, 1'b0);
      check("drain", W'(exp_q.size()), '0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/noc_out_arbiter.md
# noc_out_arbiter

Round-robin arbiter that shares one router output link (E, W, N or S, or the local PE ejection port) between the four input-side routing units that can target it. It breaks the request/full combinational loop of the routing units by issuing a registered grant, returns a per-requester `full`, and writes the winning 64-bit packet into the downstream output FIFO. One instance sits per output direction in each router.

## Interface
- `W`, default 64: packet width in bits.
- `N`, default 4: number of requesters (fixed at 4 in the router).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low (0 = reset).
- `pend`  in  N: requester i holds a packet for this output; registered at the source and independent of `full`.
- `req`  in  N: transfer strobe from requester i; combinational at the source and valid only while `full[i]`=0.
- `in_packet`  in  N*W: packet i at bits [i*W +: W].
- `full`  out  N: back-pressure to requester i; low only for the granted requester.
- `out_full`  in  1: downstream output FIFO full.
- `out_packet`  out  W: registered packet to the FIFO.
- `out_wr`  out  1: one-cycle FIFO write strobe.
- `gnt_id`  out  2: index of the current or last winner (debug).
- `err`  out  1: sticky protocol-violation flag.

## Operation
- State machine with two states: IDLE and GRANT. A registered one-hot grant `gnt_q` and a registered round-robin pointer `ptr` (2 bits) accompany the state.
- IDLE: if `pend` is not zero, select the first set bit of `pend` scanning from `ptr` upward with wrap-around (3→0). Load `gnt_q` with that winner and `gnt_id` with its index, then go to GRANT. If `pend` is zero, stay in IDLE.
- GRANT with winner i:
  - Transfer when `req[i]` && !`out_full`. On the next edge: `out_packet` ← packet i, `out_wr` ← 1, `ptr` ← i+1 (mod 4), `gnt_q` ← 0, state → IDLE.
  - If `pend[i]` falls without a transfer: `gnt_q` ← 0, state → IDLE, `ptr` unchanged.
  - Otherwise hold in GRANT, including while `out_full` is 1.
- `full[j]` = !(`gnt_q[j]` && !`out_full`). This is combinational only from registered `gnt_q` and the FIFO flag, so there is no loop through `req`.
- Protocol violation: `req[j]` asserted while `full[j]`=1. The strobe is ignored, no write occurs, and `err` ← 1. `err` is cleared only by reset.
- Packets pass through unmodified. Hop and direction fields are edited by the routing units, not here.
- Reset values: state IDLE, `gnt_q`=0, `ptr`=0, `out_packet`=0, `out_wr`=0, `gnt_id`=0, `err`=0, and therefore `full`=4'b1111.

## Timing
- Edge k: `pend[i]` rises. Edge k+1: grant is registered, so `full[i]`=0 during cycle k+1. The requester drives `req[i]` in the same cycle. Edge k+2: `out_wr`=1 and `out_packet` are valid during cycle k+2.
- Grant latency is 1 cycle and pend-to-write latency is 2 cycles.
- Sustained throughput is one packet per 2 cycles, because IDLE always takes a cycle between grants.
- `out_wr` is a single-cycle pulse and is 0 in every cycle that does not follow a transfer edge.
- `out_full` rising during GRANT forces `full[i]`=1 in that same cycle, so the requester withholds `req`. The grant is held, and the transfer proceeds on the first cycle with `out_full`=0.
- Simultaneous pends: exactly one winner per IDLE cycle. After serving i, requester i has the lowest priority, so no requester waits more than 3 other grants.
- Reset asserted mid-GRANT: all registers clear asynchronously and `out_wr` drops immediately. The packet is not written and is not lost; it remains in the requester.

## Structure
- `noc_pkg`:
  - `PKT_W`=64.
  - Requester index constants (`REQ_PE`, `REQ_0`..`REQ_3` mapping per direction).
  - State encoding typedef (IDLE=0, GRANT=1).
  - Header field positions shared with the routing units: dir_x [58], dir_y [57], hop_x [56:55], hop_y [54:53].
- One sub-module, `rr_pick`: purely combinational. Inputs `pend[3:0]` and `ptr[1:0]`; outputs a one-hot `sel[3:0]`, its index, and `any`.
- FSM, grant, pointer, output register and error flag are in `noc_out_arbiter`.

## Test plan
- Single requester, requester 2 with `pend`=4'b0100:
  - `full`=4'b1011 in cycle 1.
  - `req[2]` asserted in cycle 1 produces `out_wr`=1 with `out_packet`=packet 2 in cycle 2.
  - `ptr`=3 afterwards.
- All four pend from reset:
  - Grants in order 0, 1, 2, 3, one write every 2 cycles.
  - Requester 0 re-pending after its transfer is next served after 3.
- `out_full`=1 during GRANT of requester 1:
  - `full[1]`=1 and no `out_wr` for 5 cycles.
  - `out_full` falling leads to a write one cycle later with the packet intact.
- Granted requester 3 drops `pend` without `req`:
  - Back to IDLE with no write and `ptr` unchanged.
  - The next pending requester is granted.
- `req[1]` pulsed while requester 0 is granted:
  - No `out_wr` for requester 1 and `err`=1 sticky.
  - Requester 0's transfer still completes.
- `reset`=0 asserted in the transfer cycle:
  - `out_wr`=0 immediately and `full`=4'b1111.
  - After release, the same `pend` is re-granted from `ptr`=0.
